// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined base-3 shifter: mode encodings,
// shift-amount digit conversion and the control part of a stage payload.
package shifter_pkg;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRA = 2'b01;
  localparam logic [1:0] MODE_ROR = 2'b10;
  localparam logic [1:0] MODE_SRL = 2'b11;

  // Upper bound on pipeline depth; 3**8 covers any practical data width.
  localparam int MAX_DIGITS = 8;

  typedef logic [2*MAX_DIGITS-1:0] digits_t;

  // Valid and mode travel with every op; width-dependent fields are added by the pipe.
  typedef struct packed {
    logic       valid;
    logic [1:0] mode;
  } stage_ctrl_t;

  // Base-3 digits of a shift amount, least significant digit in bits [1:0].
  // Each digit is 0..2, so code 2'b11 never appears.
  function automatic digits_t base3_digits(input logic [31:0] shamt);
    logic [31:0] rem_v;
    digits_t     dig_v;
    rem_v = shamt;
    dig_v = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      dig_v[2*i +: 2] = 2'(rem_v % 32'd3);
      rem_v           = rem_v / 32'd3;
    end
    return dig_v;
  endfunction

endpackage

// File: rtl/shift_stage3.sv
// One combinational pipeline stage: shifts by digit*STRIDE in SLL/SRA/ROR/SRL.
// Both non-zero displacements are elaboration constants, so each is a fixed rewiring.
module shift_stage3
  import shifter_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STRIDE = 1
) (
  input  logic [1:0]       mode,
  input  logic [1:0]       digit,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  localparam int DISP1 = STRIDE;
  localparam int DISP2 = 2 * STRIDE;

  // Displacements >= WIDTH fall out naturally: zeros for logical shifts, sign bits for SRA.
  function automatic logic [WIDTH-1:0] shift_const(input logic [1:0]       mode_v,
                                                   input logic [WIDTH-1:0] data_v,
                                                   input int               disp);
    logic [WIDTH-1:0] res_v;
    int               rot_v;
    rot_v = disp % WIDTH;
    case (mode_v)
      MODE_SLL: res_v = data_v << disp;
      MODE_SRL: res_v = data_v >> disp;
      MODE_SRA: res_v = $signed(data_v) >>> disp;
      MODE_ROR: res_v = (data_v >> rot_v) | (data_v << (WIDTH - rot_v));
      default:  res_v = data_v;
    endcase
    return res_v;
  endfunction

  // Select the displacement chosen by this stage's digit.
  always_comb begin
    case (digit)
      2'd0:    data_out = data_in;
      2'd1:    data_out = shift_const(mode, data_in, DISP1);
      2'd2:    data_out = shift_const(mode, data_in, DISP2);
      default: data_out = data_in;
    endcase
  end

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined shifter: shift amount split into base-3 digits, stage k applies digit_k*3^k.
// Single global stall; the last stage register drives the output port directly.
module shifter_pipe
  import shifter_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int NUM_DIGITS = 3,
  parameter int TAG_W      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_shamt,
  input  logic [1:0]               in_mode,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_zero,
  output logic [TAG_W-1:0]         out_tag
);

  localparam int DIG_W = 2 * NUM_DIGITS;
  localparam int LAST  = NUM_DIGITS - 1;

  if (3**NUM_DIGITS < WIDTH) begin : g_depth_check
    $error("shifter_pipe: 3**NUM_DIGITS must be >= WIDTH");
  end
  if ((WIDTH < 4) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_width_check
    $error("shifter_pipe: WIDTH must be a power of two >= 4");
  end

  typedef struct packed {
    stage_ctrl_t      ctrl;
    logic [DIG_W-1:0] digits;
    logic [WIDTH-1:0] data;
    logic [TAG_W-1:0] tag;
  } stage_payload_t;

  stage_payload_t   stage_in_s   [NUM_DIGITS];
  stage_payload_t   stage_out_s  [NUM_DIGITS];
  logic [WIDTH-1:0] stage_data_s [NUM_DIGITS];
  stage_payload_t   pipe_r       [NUM_DIGITS];
  logic             zero_r;
  logic             advance_s;
  logic             unused_s;

  assign advance_s = !pipe_r[LAST].ctrl.valid || out_ready;
  assign in_ready  = advance_s && !rst;

  // Stage inputs: stage 0 takes the new op with its digits, later stages take the previous register.
  always_comb begin
    stage_in_s[0] = '{ctrl:   '{valid: in_valid, mode: in_mode},
                      digits: DIG_W'(base3_digits(32'(in_shamt))),
                      data:   in_data,
                      tag:    in_tag};
    for (int k = 1; k < NUM_DIGITS; k++) begin
      stage_in_s[k] = pipe_r[k-1];
    end
  end

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_stage
    shift_stage3 #(
      .WIDTH  (WIDTH),
      .STRIDE (3**k)
    ) u_stage (
      .mode     (stage_in_s[k].ctrl.mode),
      .digit    (stage_in_s[k].digits[2*k +: 2]),
      .data_in  (stage_in_s[k].data),
      .data_out (stage_data_s[k])
    );
  end

  // Stage outputs: payload passes through, data replaced by the shifted value.
  always_comb begin
    for (int k = 0; k < NUM_DIGITS; k++) begin
      stage_out_s[k]      = stage_in_s[k];
      stage_out_s[k].data = stage_data_s[k];
    end
  end

  // Pipeline registers: all stages move together on advance, reset drops every in-flight op.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        pipe_r[k] <= '0;
      end
      zero_r <= 1'b0;
    end else if (advance_s) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        pipe_r[k] <= stage_out_s[k];
      end
      zero_r <= stage_out_s[LAST].ctrl.valid && (stage_out_s[LAST].data == '0);
    end
  end

  assign out_valid = pipe_r[LAST].ctrl.valid;
  assign out_data  = pipe_r[LAST].data;
  assign out_tag   = pipe_r[LAST].tag;
  assign out_zero  = zero_r;

  // Already-consumed digits and the final mode have no further reader.
  always_comb begin
    unused_s = ^pipe_r[LAST].ctrl.mode;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      unused_s = unused_s ^ (^pipe_r[k].digits);
    end
  end

endmodule
